// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing one single-port SRAM among host, data and instr requesters.
// Define ARB_ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority host > data > instr.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_req_host,
    input  logic                    i_we_host,
    input  logic [ADDR_WIDTH-1:0]   i_addr_host,
    input  logic [DATA_WIDTH-1:0]   i_wdata_host,
    input  logic [DATA_WIDTH/8-1:0] i_wmask_host,
    output logic                    o_gnt_host,
    output logic                    o_rvalid_host,

    input  logic                    i_req_data,
    input  logic                    i_we_data,
    input  logic [ADDR_WIDTH-1:0]   i_addr_data,
    input  logic [DATA_WIDTH-1:0]   i_wdata_data,
    input  logic [DATA_WIDTH/8-1:0] i_wmask_data,
    output logic                    o_gnt_data,
    output logic                    o_rvalid_data,

    input  logic                    i_req_instr,
    input  logic                    i_we_instr,
    input  logic [ADDR_WIDTH-1:0]   i_addr_instr,
    input  logic [DATA_WIDTH-1:0]   i_wdata_instr,
    input  logic [DATA_WIDTH/8-1:0] i_wmask_instr,
    output logic                    o_gnt_instr,
    output logic                    o_rvalid_instr,

    output logic [DATA_WIDTH-1:0]   o_rdata,

    output logic                    o_sram_csb,
    output logic                    o_sram_web,
    output logic [ADDR_WIDTH-1:0]   o_sram_addr,
    output logic [DATA_WIDTH-1:0]   o_sram_din,
    output logic [DATA_WIDTH/8-1:0] o_sram_wmask,
    input  logic [DATA_WIDTH-1:0]   i_sram_dout
);

    localparam logic [1:0] ID_INSTR = 2'd0;
    localparam logic [1:0] ID_DATA  = 2'd1;
    localparam logic [1:0] ID_HOST  = 2'd2;

    logic [2:0] req_p0;
    logic [1:0] win_p0;
    logic       gnt_any_p0;
    logic       we_sel_p0;
    logic [1:0] last_win;
    logic [2:0] rvld_p1;
    logic       unused_ok;

    // Returns {found, id} for the first requesting port in the order a, b, c.
    function automatic logic [2:0] pick(input logic [2:0] req,
                                        input logic [1:0] a,
                                        input logic [1:0] b,
                                        input logic [1:0] c);
        if (req[a])
            return {1'b1, a};
        else if (req[b])
            return {1'b1, b};
        else if (req[c])
            return {1'b1, c};
        else
            return 3'b000;
    endfunction

    assign req_p0 = {i_req_host, i_req_data, i_req_instr};

    // Stage p0: arbitration; grants are forced off while reset is held.
    always_comb begin
        gnt_any_p0 = 1'b0;
        win_p0     = ID_INSTR;
        if (rst) begin
`ifdef ARB_ROUND_ROBIN_EN
            case (last_win)
                ID_HOST: {gnt_any_p0, win_p0} = pick(req_p0, ID_DATA, ID_INSTR, ID_HOST);
                ID_DATA: {gnt_any_p0, win_p0} = pick(req_p0, ID_INSTR, ID_HOST, ID_DATA);
                default: {gnt_any_p0, win_p0} = pick(req_p0, ID_HOST, ID_DATA, ID_INSTR);
            endcase
`else
            {gnt_any_p0, win_p0} = pick(req_p0, ID_HOST, ID_DATA, ID_INSTR);
`endif
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign unused_ok = i_we_instr;
`else
    assign unused_ok = ^{i_we_instr, last_win};
`endif

    assign o_gnt_host  = gnt_any_p0 && (win_p0 == ID_HOST);
    assign o_gnt_data  = gnt_any_p0 && (win_p0 == ID_DATA);
    assign o_gnt_instr = gnt_any_p0 && (win_p0 == ID_INSTR);

    always_comb begin
        o_sram_csb   = 1'b1;
        o_sram_web   = 1'b1;
        o_sram_addr  = '0;
        o_sram_din   = '0;
        o_sram_wmask = '0;
        we_sel_p0    = 1'b0;
        if (gnt_any_p0) begin
            o_sram_csb = 1'b0;
            case (win_p0)
                ID_HOST: begin
                    we_sel_p0    = i_we_host;
                    o_sram_addr  = i_addr_host;
                    o_sram_din   = i_wdata_host;
                    o_sram_wmask = i_wmask_host;
                end
                ID_DATA: begin
                    we_sel_p0    = i_we_data;
                    o_sram_addr  = i_addr_data;
                    o_sram_din   = i_wdata_data;
                    o_sram_wmask = i_wmask_data;
                end
                default: begin
                    // Fetch port is read-only whatever its we input says.
                    we_sel_p0    = 1'b0;
                    o_sram_addr  = i_addr_instr;
                    o_sram_din   = i_wdata_instr;
                    o_sram_wmask = i_wmask_instr;
                end
            endcase
            o_sram_web = ~we_sel_p0;
        end
    end

    // Stage p1: one-hot owner of the read issued last cycle, plus arbitration history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_win <= ID_INSTR;
            rvld_p1  <= 3'b000;
        end else begin
            rvld_p1 <= (gnt_any_p0 && !we_sel_p0)
                       ? {o_gnt_host, o_gnt_data, o_gnt_instr} : 3'b000;
            if (gnt_any_p0)
                last_win <= win_p0;
        end
    end

    assign o_rvalid_host  = rvld_p1[2];
    assign o_rvalid_data  = rvld_p1[1];
    assign o_rvalid_instr = rvld_p1[0];
    assign o_rdata        = i_sram_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port SRAM attached.
// Expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it defined.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          preload = 1'b1;

    logic          req_host = 0, we_host = 0, req_data = 0, we_data = 0, req_instr = 0, we_instr = 0;
    logic [AW-1:0] addr_host = '0, addr_data = '0, addr_instr = '0;
    logic [DW-1:0] wdata_host = '0, wdata_data = '0, wdata_instr = '0;
    logic [MW-1:0] wmask_host = '0, wmask_data = '0, wmask_instr = '0;

    logic          gnt_host, gnt_data, gnt_instr;
    logic          rvalid_host, rvalid_data, rvalid_instr;
    logic [DW-1:0] rdata;
    logic          sram_csb, sram_web;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_dout = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req_host(req_host), .i_we_host(we_host), .i_addr_host(addr_host),
        .i_wdata_host(wdata_host), .i_wmask_host(wmask_host),
        .o_gnt_host(gnt_host), .o_rvalid_host(rvalid_host),
        .i_req_data(req_data), .i_we_data(we_data), .i_addr_data(addr_data),
        .i_wdata_data(wdata_data), .i_wmask_data(wmask_data),
        .o_gnt_data(gnt_data), .o_rvalid_data(rvalid_data),
        .i_req_instr(req_instr), .i_we_instr(we_instr), .i_addr_instr(addr_instr),
        .i_wdata_instr(wdata_instr), .i_wmask_instr(wmask_instr),
        .o_gnt_instr(gnt_instr), .o_rvalid_instr(rvalid_instr),
        .o_rdata(rdata),
        .o_sram_csb(sram_csb), .o_sram_web(sram_web), .o_sram_addr(sram_addr),
        .o_sram_din(sram_din), .o_sram_wmask(sram_wmask), .i_sram_dout(sram_dout)
    );

    // Behavioural OpenRAM-style macro: registered read data, byte-masked writes.
    always @(posedge clk) begin
        if (preload) begin
            mem[10'h010] = 32'hDEADBEEF;
            mem[10'h020] = 32'hAABBCCDD;
            mem[10'h030] = 32'h0BADF00D;
            mem[10'h040] = 32'h55667788;
        end else if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < MW; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] = sram_din[8*b +: 8];
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    function automatic logic [DW-1:0] contention_data(input logic [2:0] g);
        case (g)
            3'b100:  return 32'hDEADBEEF;
            3'b010:  return 32'h55667788;
            default: return 32'h0BADF00D;
        endcase
    endfunction

    task automatic idle();
        req_host = 0; req_data = 0; req_instr = 0;
        we_host = 0; we_data = 0; we_instr = 0;
    endtask

    task automatic test_reset();
        req_host = 1; req_data = 1; req_instr = 1;
        addr_host = 10'h010; addr_data = 10'h020; addr_instr = 10'h030;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({gnt_host, gnt_data, gnt_instr} !== 3'b000) begin
                errors++; $display("FAIL reset_gnt cyc %0d: got %b want 000", i, {gnt_host, gnt_data, gnt_instr});
            end
            checks++;
            if ({rvalid_host, rvalid_data, rvalid_instr} !== 3'b000) begin
                errors++; $display("FAIL reset_rvalid cyc %0d: got %b want 000", i, {rvalid_host, rvalid_data, rvalid_instr});
            end
            checks++;
            if (sram_csb !== 1'b1) begin
                errors++; $display("FAIL reset_csb cyc %0d: got %b want 1", i, sram_csb);
            end
        end
        @(negedge clk);
        preload = 0;
        rst = 1;
        #1;
        checks++;
        if ({gnt_host, gnt_data, gnt_instr} !== 3'b100) begin
            errors++; $display("FAIL release_gnt: got %b want 100", {gnt_host, gnt_data, gnt_instr});
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rvalid_host !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL release_read: got rvalid=%b data=%h want 1 deadbeef", rvalid_host, rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        req_instr = 1; addr_instr = 10'h010;
        #1;
        checks++;
        if (gnt_instr !== 1'b1 || sram_csb !== 1'b0 || sram_web !== 1'b1 || sram_addr !== 10'h010) begin
            errors++; $display("FAIL read_issue: got gnt=%b csb=%b web=%b addr=%h want 1 0 1 010",
                               gnt_instr, sram_csb, sram_web, sram_addr);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({rvalid_host, rvalid_data, rvalid_instr} !== 3'b001 || rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_return: got rvalid=%b data=%h want 001 deadbeef",
                               {rvalid_host, rvalid_data, rvalid_instr}, rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid_instr !== 1'b0) begin
            errors++; $display("FAIL read_one_cycle: got rvalid=%b want 0", rvalid_instr);
        end
        @(negedge clk);
    endtask

    task automatic test_byte_write();
        req_data = 1; we_data = 1; addr_data = 10'h020;
        wdata_data = 32'h11223344; wmask_data = 4'b0100;
        #1;
        checks++;
        if (gnt_data !== 1'b1 || sram_web !== 1'b0 || sram_wmask !== 4'b0100 ||
            sram_din !== 32'h11223344 || sram_addr !== 10'h020) begin
            errors++; $display("FAIL write_issue: got gnt=%b web=%b mask=%b din=%h addr=%h want 1 0 0100 11223344 020",
                               gnt_data, sram_web, sram_wmask, sram_din, sram_addr);
        end
        @(negedge clk);
        we_data = 0; wmask_data = 4'b0000;
        #1;
        checks++;
        if ({rvalid_host, rvalid_data, rvalid_instr} !== 3'b000) begin
            errors++; $display("FAIL write_no_rvalid: got %b want 000", {rvalid_host, rvalid_data, rvalid_instr});
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rvalid_data !== 1'b1 || rdata !== 32'hAA22CCDD) begin
            errors++; $display("FAIL write_readback: got rvalid=%b data=%h want 1 aa22ccdd", rvalid_data, rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [2:0] exp_g;
        logic [2:0] prev_g;
        logic [2:0] got;
        rst = 0;
        req_host = 1; req_data = 1; req_instr = 1;
        addr_host = 10'h010; addr_data = 10'h040; addr_instr = 10'h030;
        @(negedge clk);
        rst = 1;
        prev_g = 3'b000;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (i % 3 == 0) ? 3'b100 : (i % 3 == 1) ? 3'b010 : 3'b001;
`else
            exp_g = 3'b100;
`endif
            #1;
            got = {gnt_host, gnt_data, gnt_instr};
            checks++;
            if (got !== exp_g) begin
                errors++; $display("FAIL contend_gnt cyc %0d: got %b want %b", i, got, exp_g);
            end
            got = {rvalid_host, rvalid_data, rvalid_instr};
            checks++;
            if (got !== prev_g) begin
                errors++; $display("FAIL contend_rvalid cyc %0d: got %b want %b", i, got, prev_g);
            end
            if (prev_g != 3'b000) begin
                checks++;
                if (rdata !== contention_data(prev_g)) begin
                    errors++; $display("FAIL contend_rdata cyc %0d: got %h want %h", i, rdata, contention_data(prev_g));
                end
            end
            prev_g = exp_g;
            @(negedge clk);
        end
        idle();
        #1;
        got = {rvalid_host, rvalid_data, rvalid_instr};
        checks++;
        if (got !== prev_g || rdata !== contention_data(prev_g)) begin
            errors++; $display("FAIL contend_last: got rvalid=%b data=%h want %b %h", got, rdata, prev_g, contention_data(prev_g));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        req_data = 1; addr_data = 10'h040;
        #1;
        checks++;
        if (gnt_data !== 1'b1) begin
            errors++; $display("FAIL midrst_gnt: got %b want 1", gnt_data);
        end
        rst = 0;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rvalid_data !== 1'b0) begin
            errors++; $display("FAIL midrst_rvalid: got %b want 0", rvalid_data);
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_withdrawn();
        req_host = 1; addr_host = 10'h010;
        req_instr = 1; addr_instr = 10'h030;
        #1;
        checks++;
        if ({gnt_host, gnt_data, gnt_instr} !== 3'b100 || sram_addr !== 10'h010) begin
            errors++; $display("FAIL withdraw_arb: got gnt=%b addr=%h want 100 010",
                               {gnt_host, gnt_data, gnt_instr}, sram_addr);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (sram_csb !== 1'b1 || sram_web !== 1'b1 || sram_addr !== 10'h000) begin
            errors++; $display("FAIL withdraw_idle: got csb=%b web=%b addr=%h want 1 1 000", sram_csb, sram_web, sram_addr);
        end
        checks++;
        if ({rvalid_host, rvalid_data, rvalid_instr} !== 3'b100 || rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL withdraw_rvalid: got rvalid=%b data=%h want 100 deadbeef",
                               {rvalid_host, rvalid_data, rvalid_instr}, rdata);
        end
        @(negedge clk); #1;
        checks++;
        if ({rvalid_host, rvalid_data, rvalid_instr} !== 3'b000) begin
            errors++; $display("FAIL withdraw_after: got %b want 000", {rvalid_host, rvalid_data, rvalid_instr});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_reset_mid_read();
        test_withdrawn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
